// File: rtl/tone_player.sv
// tone_player: plays one timed note per start request.
//   The prescale value is latched on start and clk is divided by it to step an
//   8-bit phase accumulator. Each note is a PLAY phase (NOTE_CYCLES) followed
//   by a silent MUTE phase (GAP_CYCLES), then a noteDone pulse on return to IDLE.
// Ports:
//   clk           system clock
//   resetN        asynchronous active-low reset
//   start         one-cycle note request (retriggers while busy)
//   preScaleValue clk cycles per phase step, clamped to >= 2 on capture
//   soundSwitch   global mute, 1 = audible
//   phase         phase index for the sine table
//   toneOut       square wave, phase[7] while audible
//   soundEnable   codec/speaker enable
//   busy          high in PLAY or MUTE
//   noteDone      one-cycle pulse on entry to IDLE
module tone_player #(
  parameter int unsigned NOTE_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic [9:0] preScaleValue,
  input  logic       soundSwitch,
  output logic [7:0] phase,
  output logic       toneOut,
  output logic       soundEnable,
  output logic       busy,
  output logic       noteDone
);

  localparam int unsigned PS_W    = 10;
  localparam int unsigned PH_W    = 8;
  localparam int unsigned MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int unsigned DUR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_MUTE = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [PS_W-1:0]   presc_q, presc_n;
  logic [PS_W-1:0]   div_q, div_n;
  logic [DUR_W-1:0]  dur_q, dur_n;
  logic [PH_W-1:0]   phase_n;
  logic              tone_n, snd_en_n, busy_n, done_n;

  // Next-state, counters and registered-output next values
  always_comb begin
    state_n  = state_q;
    presc_n  = presc_q;
    div_n    = div_q;
    dur_n    = dur_q;
    phase_n  = phase;
    tone_n   = 1'b0;
    snd_en_n = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state_q)
      S_IDLE:  if (start) state_n = S_PLAY;
      S_PLAY:  if (dur_q == NOTE_LAST) state_n = S_MUTE;
      S_MUTE:  if (dur_q == GAP_LAST) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // A request in any state (including the last MUTE cycle) restarts the note
    if (start) state_n = S_PLAY;

    if (start) begin
      presc_n = (preScaleValue < PS_W'(2)) ? PS_W'(2) : preScaleValue;
      div_n   = '0;
      dur_n   = '0;
      phase_n = '0;
    end else if (state_n != state_q) begin
      dur_n   = '0;
      div_n   = '0;
      phase_n = '0;
    end else if (state_q == S_PLAY) begin
      dur_n = dur_q + DUR_W'(1);
      if (div_q == presc_q - PS_W'(1)) begin
        div_n   = '0;
        phase_n = phase + PH_W'(1);
      end else begin
        div_n = div_q + PS_W'(1);
      end
    end else if (state_q == S_MUTE) begin
      dur_n = dur_q + DUR_W'(1);
    end

    busy_n   = (state_n != S_IDLE);
    snd_en_n = (state_n == S_PLAY) && soundSwitch;
    // Follows the current phase bit; suppressed when the note ends or restarts
    tone_n   = (state_q == S_PLAY) && (state_n == S_PLAY) && !start
               && phase[PH_W-1] && soundSwitch;
    done_n   = (state_q == S_MUTE) && (state_n == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      div_q       <= '0;
      dur_q       <= '0;
      phase       <= '0;
      toneOut     <= 1'b0;
      soundEnable <= 1'b0;
      busy        <= 1'b0;
      noteDone    <= 1'b0;
    end else begin
      state_q     <= state_n;
      presc_q     <= presc_n;
      div_q       <= div_n;
      dur_q       <= dur_n;
      phase       <= phase_n;
      toneOut     <= tone_n;
      soundEnable <= snd_en_n;
      busy        <= busy_n;
      noteDone    <= done_n;
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: directed bench for tone_player with a short note (1000/100).
// Cycle k is the clock period after the k-th edge counted from the edge that
// samples start (cycle 1 is the first PLAY cycle). Outputs are sampled 1 ns
// after each rising edge.
module tb_tone_player;

  localparam int unsigned NOTE = 1000;
  localparam int unsigned GAP  = 100;

  logic       clk = 1'b0;
  logic       resetN;
  logic       start;
  logic [9:0] preScaleValue;
  logic       soundSwitch;
  logic [7:0] phase;
  logic       toneOut;
  logic       soundEnable;
  logic       busy;
  logic       noteDone;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int done_seen = 0;
  int base;

  tone_player #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .resetN(resetN), .start(start), .preScaleValue(preScaleValue),
    .soundSwitch(soundSwitch), .phase(phase), .toneOut(toneOut),
    .soundEnable(soundEnable), .busy(busy), .noteDone(noteDone)
  );

  always #5 clk = ~clk;

  // Counts noteDone pulses (one per high cycle)
  always @(negedge clk) if (noteDone === 1'b1) done_seen = done_seen + 1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic begin_note(input logic [9:0] p);
    preScaleValue = p;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; start = 1'b0; preScaleValue = 10'd4; soundSwitch = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({phase, toneOut, soundEnable, busy, noteDone} !== 12'd0)
      $display("FAIL reset_outputs: got %h want 000", {phase, toneOut, soundEnable, busy, noteDone});
    else pass_cnt++;
    resetN = 1'b1;
    tick(); tick();
    total_cnt++;
    if (busy !== 1'b0 || noteDone !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b noteDone=%b want 0 0", busy, noteDone);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    base = done_seen;
    begin_note(10'd4);
    total_cnt++;
    if ({busy, soundEnable, noteDone} !== 3'b110 || phase !== 8'd0)
      $display("FAIL basic_c1: busy/en/done=%b phase=%0d want 110 0", {busy, soundEnable, noteDone}, phase);
    else pass_cnt++;
    run_to(NOTE);
    total_cnt++;
    if ({busy, soundEnable} !== 2'b11)
      $display("FAIL basic_c1000: busy/en=%b want 11", {busy, soundEnable});
    else pass_cnt++;
    run_to(NOTE + 1);
    total_cnt++;
    if ({busy, soundEnable, toneOut} !== 3'b100 || phase !== 8'd0)
      $display("FAIL basic_mute_entry: busy/en/tone=%b phase=%0d want 100 0", {busy, soundEnable, toneOut}, phase);
    else pass_cnt++;
    run_to(NOTE + GAP);
    total_cnt++;
    if ({busy, noteDone} !== 2'b10)
      $display("FAIL basic_c1100: busy/done=%b want 10", {busy, noteDone});
    else pass_cnt++;
    run_to(NOTE + GAP + 1);
    total_cnt++;
    if ({busy, noteDone} !== 2'b01)
      $display("FAIL basic_c1101: busy/done=%b want 01", {busy, noteDone});
    else pass_cnt++;
    run_to(NOTE + GAP + 2);
    total_cnt++;
    if (noteDone !== 1'b0)
      $display("FAIL basic_done_width: noteDone=%b want 0", noteDone);
    else pass_cnt++;
    run_to(NOTE + GAP + 10);
    total_cnt++;
    if (done_seen - base !== 1)
      $display("FAIL basic_done_count: got %0d want 1", done_seen - base);
    else pass_cnt++;
  endtask

  task automatic test_waveform();
    begin_note(10'd4);
    preScaleValue = 10'd50;
    run_to(4);
    total_cnt++;
    if (phase !== 8'd0) $display("FAIL wave_c4: phase=%0d want 0", phase);
    else pass_cnt++;
    run_to(5);
    total_cnt++;
    if (phase !== 8'd1) $display("FAIL wave_first_tick: phase=%0d want 1", phase);
    else pass_cnt++;
    run_to(512);
    total_cnt++;
    if (phase !== 8'd127) $display("FAIL wave_c512: phase=%0d want 127", phase);
    else pass_cnt++;
    run_to(513);
    total_cnt++;
    if (phase !== 8'd128 || toneOut !== 1'b0)
      $display("FAIL wave_c513: phase=%0d tone=%b want 128 0", phase, toneOut);
    else pass_cnt++;
    run_to(514);
    total_cnt++;
    if (phase !== 8'd128 || toneOut !== 1'b1)
      $display("FAIL wave_tone_rise: phase=%0d tone=%b want 128 1", phase, toneOut);
    else pass_cnt++;
    run_to(NOTE);
    total_cnt++;
    if (phase !== 8'd249 || toneOut !== 1'b1)
      $display("FAIL wave_c1000: phase=%0d tone=%b want 249 1", phase, toneOut);
    else pass_cnt++;
    run_to(NOTE + 1);
    total_cnt++;
    if (toneOut !== 1'b0) $display("FAIL wave_tone_mute: tone=%b want 0", toneOut);
    else pass_cnt++;
    run_to(NOTE + GAP + 5);
  endtask

  task automatic test_clamp();
    logic [9:0] pv [2];
    pv[0] = 10'd0;
    pv[1] = 10'd1;
    for (int i = 0; i < 2; i++) begin
      begin_note(pv[i]);
      preScaleValue = 10'd300;
      run_to(3);
      total_cnt++;
      if (phase !== 8'd1) $display("FAIL clamp%0d_c3: phase=%0d want 1", i, phase);
      else pass_cnt++;
      run_to(511);
      total_cnt++;
      if (phase !== 8'd255) $display("FAIL clamp%0d_c511: phase=%0d want 255", i, phase);
      else pass_cnt++;
      run_to(512);
      total_cnt++;
      if (phase !== 8'd255) $display("FAIL clamp%0d_c512: phase=%0d want 255", i, phase);
      else pass_cnt++;
      run_to(513);
      total_cnt++;
      if (phase !== 8'd0) $display("FAIL clamp%0d_wrap: phase=%0d want 0", i, phase);
      else pass_cnt++;
      run_to(NOTE + GAP + 5);
    end
  endtask

  task automatic test_retrigger();
    base = done_seen;
    begin_note(10'd4);
    run_to(500);
    total_cnt++;
    if (phase !== 8'd124) $display("FAIL retrig_c500: phase=%0d want 124", phase);
    else pass_cnt++;
    preScaleValue = 10'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (phase !== 8'd0 || {busy, soundEnable} !== 2'b11)
      $display("FAIL retrig_c501: phase=%0d busy/en=%b want 0 11", phase, {busy, soundEnable});
    else pass_cnt++;
    run_to(508);
    total_cnt++;
    if (phase !== 8'd0) $display("FAIL retrig_c508: phase=%0d want 0", phase);
    else pass_cnt++;
    run_to(509);
    total_cnt++;
    if (phase !== 8'd1) $display("FAIL retrig_tick8: phase=%0d want 1", phase);
    else pass_cnt++;
    run_to(NOTE + 1);
    total_cnt++;
    if (soundEnable !== 1'b1) $display("FAIL retrig_c1001: en=%b want 1", soundEnable);
    else pass_cnt++;
    run_to(1500);
    total_cnt++;
    if (soundEnable !== 1'b1) $display("FAIL retrig_c1500: en=%b want 1", soundEnable);
    else pass_cnt++;
    run_to(1501);
    total_cnt++;
    if ({busy, soundEnable} !== 2'b10) $display("FAIL retrig_c1501: busy/en=%b want 10", {busy, soundEnable});
    else pass_cnt++;
    run_to(1601);
    total_cnt++;
    if ({busy, noteDone} !== 2'b01) $display("FAIL retrig_c1601: busy/done=%b want 01", {busy, noteDone});
    else pass_cnt++;
    run_to(1610);
    total_cnt++;
    if (done_seen - base !== 1) $display("FAIL retrig_done_count: got %0d want 1", done_seen - base);
    else pass_cnt++;
  endtask

  task automatic test_mute();
    base = done_seen;
    soundSwitch = 1'b0;
    begin_note(10'd4);
    total_cnt++;
    if ({busy, soundEnable} !== 2'b10) $display("FAIL mute_c1: busy/en=%b want 10", {busy, soundEnable});
    else pass_cnt++;
    run_to(513);
    total_cnt++;
    if (phase !== 8'd128) $display("FAIL mute_c513: phase=%0d want 128", phase);
    else pass_cnt++;
    run_to(514);
    total_cnt++;
    if ({toneOut, soundEnable} !== 2'b00) $display("FAIL mute_c514: tone/en=%b want 00", {toneOut, soundEnable});
    else pass_cnt++;
    run_to(NOTE + GAP);
    total_cnt++;
    if ({busy, noteDone} !== 2'b10) $display("FAIL mute_c1100: busy/done=%b want 10", {busy, noteDone});
    else pass_cnt++;
    run_to(NOTE + GAP + 1);
    total_cnt++;
    if ({busy, noteDone} !== 2'b01) $display("FAIL mute_c1101: busy/done=%b want 01", {busy, noteDone});
    else pass_cnt++;
    run_to(NOTE + GAP + 5);
    total_cnt++;
    if (done_seen - base !== 1) $display("FAIL mute_done_count: got %0d want 1", done_seen - base);
    else pass_cnt++;
    soundSwitch = 1'b1;
  endtask

  task automatic test_reset_mid();
    begin_note(10'd4);
    run_to(300);
    total_cnt++;
    if (phase !== 8'd74 || busy !== 1'b1)
      $display("FAIL rstmid_c300: phase=%0d busy=%b want 74 1", phase, busy);
    else pass_cnt++;
    resetN = 1'b0;
    #1;
    total_cnt++;
    if ({phase, toneOut, soundEnable, busy, noteDone} !== 12'd0)
      $display("FAIL rstmid_async: got %h want 000", {phase, toneOut, soundEnable, busy, noteDone});
    else pass_cnt++;
    tick(); tick();
    resetN = 1'b1;
    base = done_seen;
    for (int i = 0; i < NOTE + GAP + 50; i++) tick();
    total_cnt++;
    if (done_seen - base !== 0 || busy !== 1'b0)
      $display("FAIL rstmid_no_done: pulses=%0d busy=%b want 0 0", done_seen - base, busy);
    else pass_cnt++;
    begin_note(10'd4);
    run_to(NOTE);
    total_cnt++;
    if ({busy, soundEnable} !== 2'b11) $display("FAIL rstmid_replay_c1000: busy/en=%b want 11", {busy, soundEnable});
    else pass_cnt++;
    run_to(NOTE + GAP + 1);
    total_cnt++;
    if ({busy, noteDone} !== 2'b01) $display("FAIL rstmid_replay_c1101: busy/done=%b want 01", {busy, noteDone});
    else pass_cnt++;
    run_to(NOTE + GAP + 5);
    total_cnt++;
    if (done_seen - base !== 1) $display("FAIL rstmid_replay_count: got %0d want 1", done_seen - base);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_waveform();
    test_clamp();
    test_retrigger();
    test_mute();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
